// File: rtl/jacobi_grid_stream_bridge.sv
// Host-side bridge for the Jacobi solver's flat-bus interface: it collects a grid from the input
// stream, runs the solver once, and streams the solved grid back out.
module jacobi_grid_stream_bridge #(
   parameter int unsigned M              = 4,
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned TIMEOUT_CYCLES = 65536
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               in_data,
   output logic                           solver_start,
   output logic [(M+2)*(M+2)*WIDTH-1:0]   u_in_flat,
   input  logic                           solver_done,
   input  logic [(M+2)*(M+2)*WIDTH-1:0]   u_out_flat,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH-1:0]               out_data,
   output logic                           out_last,
   output logic                           busy,
   output logic                           timeout
);

   localparam int unsigned N  = (M+2)*(M+2);
   localparam int unsigned KW = $clog2(N+1);
   localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES+1);
   localparam logic [KW-1:0] K_LAST = KW'(N-1);
   localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES-1);

   typedef enum logic [1:0] {COLLECT, START, WAIT_DONE, EMIT} state_t;

   state_t             state;
   logic [KW-1:0]      k;
   logic [KW-1:0]      e;
   logic [TW-1:0]      cnt;
   logic [N*WIDTH-1:0] shadow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= COLLECT;
         k            <= '0;
         e            <= '0;
         cnt          <= '0;
         shadow       <= '0;
         in_ready     <= 1'b0;
         solver_start <= 1'b0;
         u_in_flat    <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_last     <= 1'b0;
         busy         <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  u_in_flat[int'(k)*WIDTH +: WIDTH] <= in_data;
                  if (k == '0)
                     timeout <= 1'b0;
                  if (k == K_LAST) begin
                     k            <= '0;
                     in_ready     <= 1'b0;
                     solver_start <= 1'b1;
                     busy         <= 1'b1;
                     state        <= START;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            START: begin
               solver_start <= 1'b0;
               cnt          <= '0;
               state        <= WAIT_DONE;
            end
            WAIT_DONE: begin
               // done is checked first so it wins over a same-cycle expiry
               if (solver_done) begin
                  shadow    <= u_out_flat;
                  out_data  <= u_out_flat[WIDTH-1:0];
                  out_valid <= 1'b1;
                  out_last  <= (N == 1);
                  e         <= '0;
                  state     <= EMIT;
               end else if (TIMEOUT_CYCLES != 0 && cnt == T_LAST) begin
                  timeout  <= 1'b1;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= COLLECT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (e == K_LAST) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                     e         <= '0;
                     k         <= '0;
                     state     <= COLLECT;
                  end else begin
                     e        <= e + 1'b1;
                     out_data <= shadow[(int'(e)+1)*WIDTH +: WIDTH];
                     out_last <= ((e + 1'b1) == K_LAST);
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_jacobi_grid_stream_bridge.sv
// Scoreboard bench for jacobi_grid_stream_bridge. A stub solver returns each word plus one,
// then scrambles its result bus after done so that the output snapshot is exercised.
module tb_jacobi_grid_stream_bridge;
   localparam int M  = 4;
   localparam int W  = 32;
   localparam int N  = (M+2)*(M+2);
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid, in_ready, solver_start, solver_done;
   logic out_valid, out_ready, out_last, busy, timeout;
   logic [W-1:0] in_data, out_data;
   logic [N*W-1:0] u_in_flat, u_out_flat;
   logic stub_done = 1'b0;
   logic spur_done = 1'b0;

   assign solver_done = stub_done | spur_done;

   jacobi_grid_stream_bridge #(.M(M), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .solver_start(solver_start), .u_in_flat(u_in_flat),
      .solver_done(solver_done), .u_out_flat(u_out_flat),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [W-1:0] exp_q[$];
   int e_idx = 0;
   int done_delay = 5;
   int rdy_pct = 100;
   int n_start = 0;
   logic [W-1:0] grid[N];

   task automatic chk(string name, logic [63:0] got, logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // stub solver
   initial begin
      logic [N*W-1:0] ex;
      u_out_flat = '0;
      forever begin
         @(negedge clk);
         if (!rst && solver_start) begin
            n_start++;
            for (int i = 0; i < N; i++) ex[i*W +: W] = grid[i];
            chk("u_in_flat", (u_in_flat === ex) ? 1 : 0, 1);
            for (int i = 0; i < N; i++) u_out_flat[i*W +: W] = grid[i] + 1;
            if (done_delay >= 0) begin
               repeat (done_delay) @(negedge clk);
               stub_done = 1'b1;
               @(negedge clk);
               stub_done = 1'b0;
               for (int i = 0; i < N; i++) u_out_flat[i*W +: W] = $urandom;
            end
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 out_ready = ($urandom_range(99) < rdy_pct);
      end
   end

   // monitor
   initial begin
      logic prev_stall;
      logic [W-1:0] prev_data;
      prev_stall = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (busy) chk("in_ready_low_busy", in_ready, 0);
            if (prev_stall) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_data", out_data, prev_data);
            end
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out", out_valid, 0);
               end else begin
                  chk("out_data", out_data, exp_q[0]);
                  chk("out_last", out_last, (e_idx == N-1) ? 1 : 0);
                  if (out_ready) begin
                     void'(exp_q.pop_front());
                     e_idx = (e_idx == N-1) ? 0 : e_idx + 1;
                  end
               end
            end else begin
               chk("out_last_idle", out_last, 0);
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
         end
      end
   end

   task automatic send_grid(bit seq, int gap_pct, bit expect_out);
      int wait_n;
      for (int i = 0; i < N; i++) grid[i] = seq ? W'(i) : W'($urandom);
      if (expect_out) for (int i = 0; i < N; i++) exp_q.push_back(grid[i] + 1);
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b0;
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) @(negedge clk);
         in_valid = 1'b1;
         in_data = grid[i];
         wait_n = 0;
         while (!in_ready && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
         end
         if (!in_ready) begin
            chk("accept_wait", in_ready, 1);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         @(negedge clk);
         if (i == 0) chk("timeout_cleared", timeout, 0);
         if (i == N-1) begin
            in_valid = 1'b0;
            chk("start_pulse", solver_start, 1);
            chk("busy_start", busy, 1);
            chk("in_ready_start", in_ready, 0);
         end
      end
      @(negedge clk);
      chk("start_one_cycle", solver_start, 0);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !out_valid && !busy && in_ready) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", (exp_q.size() == 0 && !busy) ? 1 : 0, 1);
   endtask

   initial begin
      int n;
      in_valid = 1'b0;
      in_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_start", solver_start, 0);
      chk("rst_u_in", (u_in_flat == '0) ? 1 : 0, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);

      // back-to-back sequential grid
      send_grid(1, 0, 1);
      wait_drain();
      chk("start_count", n_start, 1);

      // random data, input gaps, random backpressure
      rdy_pct = 50;
      for (int g = 0; g < 3; g++) begin
         send_grid(0, 30, 1);
         wait_drain();
      end
      chk("start_count_rand", n_start, 4);

      // spurious done while collecting
      spur_done = 1'b1;
      repeat (3) @(negedge clk);
      spur_done = 1'b0;
      @(negedge clk);
      chk("spur_out_valid", out_valid, 0);
      chk("spur_busy", busy, 0);
      chk("spur_in_ready", in_ready, 1);

      // timeout: solver never finishes
      done_delay = -1;
      send_grid(0, 0, 0);
      repeat (15) @(negedge clk);
      chk("to_not_yet", timeout, 0);
      chk("to_busy_hold", busy, 1);
      @(negedge clk);
      chk("to_set", timeout, 1);
      chk("to_busy_clr", busy, 0);
      chk("to_in_ready", in_ready, 1);

      // done on the final timeout cycle wins
      done_delay = TO;
      send_grid(0, 20, 1);
      wait_drain();
      chk("done_wins_timeout", timeout, 0);

      // reset in the middle of the output stream
      done_delay = 5;
      rdy_pct = 70;
      send_grid(0, 0, 1);
      n = 0;
      while (e_idx != 10 && n < 1000) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("reached_word10", e_idx, 10);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_out_last", out_last, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_u_in", (u_in_flat == '0) ? 1 : 0, 1);
      exp_q.delete();
      e_idx = 0;
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      send_grid(0, 10, 1);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
